// File: rtl/multi_io_pkg.sv
// Shared constants and types for the FE-I4 command-sequencer top.
`timescale 1ns/1ps
package multi_io_pkg;

    // Register map
    localparam logic [15:0] ADDR_CMD_BASE = 16'h0000;
    localparam logic [15:0] ADDR_START    = 16'h0001;
    localparam logic [15:0] ADDR_EN_EXT   = 16'h0002;
    localparam logic [15:0] ADDR_SIZE     = 16'h0003;
    localparam logic [15:0] ADDR_REPEAT   = 16'h0005;
    localparam logic [15:0] ADDR_DATA     = 16'h0010;

    // FE-I4 command opcodes
    localparam logic [4:0] CMD_LV1    = 5'b11101;
    localparam logic [4:0] CMD_FIELD1 = 5'b10110;
    localparam logic [3:0] CMD_BCR    = 4'b0001;
    localparam logic [3:0] CMD_ECR    = 4'b0010;
    localparam logic [3:0] CMD_CAL    = 4'b0100;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_SEND = 1'b1
    } seq_state_t;

    // Bus write as captured while WR_B is low
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_wr_t;

    // Patterns go out MSB of each byte first
    function automatic logic [2:0] bit_in_byte(input logic [2:0] bit_lsbs);
        return 3'd7 - bit_lsbs;
    endfunction

endpackage

// File: rtl/multi_io_top_cmd_seq_core.sv
// Pattern RAM plus the bit/repeat counters and IDLE/SEND FSM that serialise it.
`timescale 1ns/1ps
module cmd_seq_core
    import multi_io_pkg::*;
#(
    parameter int MEM_BYTES = 2048,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          FCLK_IN,
    input  logic          RST_N,
    input  logic          soft_rst,
    input  logic          start,
    input  logic [15:0]   size,
    input  logic [15:0]   repeat_cnt,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [7:0]    mem_wdata,
    input  logic [AW-1:0] mem_raddr,
    output logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          cmd_data
);

    logic [7:0]    mem [MEM_BYTES];
    seq_state_t    state_q, state_d;
    logic [15:0]   bit_cnt_q, bit_cnt_d;
    logic [15:0]   rep_cnt_q, rep_cnt_d;
    logic [AW-1:0] cur_byte;
    logic          cur_bit;
    logic          last_bit;

    // Pattern memory write port; contents survive reset
    always_ff @(posedge FCLK_IN) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign mem_rdata = mem[mem_raddr];
    assign cur_byte  = AW'(bit_cnt_q >> 3);
    assign cur_bit   = mem[cur_byte][bit_in_byte(bit_cnt_q[2:0])];
    // Compare as >= so a mid-send SIZE shrink still terminates the pass
    assign last_bit  = ({1'b0, bit_cnt_q} + 17'd1) >= {1'b0, size};

    // State and counter registers
    always_ff @(posedge FCLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= SEQ_IDLE;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Next state, counters and serial output
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        busy      = (state_q == SEQ_SEND);
        cmd_data  = busy & cur_bit;
        if (soft_rst) begin
            state_d   = SEQ_IDLE;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (start && size != 16'd0) begin
                        state_d   = SEQ_SEND;
                        bit_cnt_d = '0;
                        rep_cnt_d = (repeat_cnt == 16'd0) ? 16'd1 : repeat_cnt;
                    end
                end
                SEQ_SEND: begin
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (rep_cnt_q <= 16'd1) state_d = SEQ_IDLE;
                        else rep_cnt_d = rep_cnt_q - 16'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 16'd1;
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/multi_io_top.sv
// FE-I4 readout top: USB-side bus decode, trigger sync and command sequencer.
`timescale 1ns/1ps
module multi_io_top
    import multi_io_pkg::*;
#(
    parameter int         MEM_BYTES = 2048,
    parameter logic [7:0] VERSION   = 8'd1
) (
    input  logic        FCLK_IN,
    input  logic        RST_N,
    input  logic [15:0] ADD,
    inout  wire  [7:0]  BUS_DATA,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        RJ45_TRIGGER,
    output logic        CMD_CLK,
    output logic        CMD_DATA,
    output logic [2:0]  TX,
    output logic        LED1
);

    localparam int          AW       = $clog2(MEM_BYTES);
    localparam logic [16:0] ADDR_END = 17'(ADDR_DATA) + 17'(MEM_BYTES);

    bus_wr_t       wr_q;
    logic [2:0]    wr_sync, trig_sync;
    logic          wr_rise, trig_rise;
    logic          start_q, en_ext_q;
    logic [15:0]   size_q, rep_q;
    logic          in_mem_wr, mem_we, soft_rst;
    logic [7:0]    mem_rdata, rd_data;
    logic          rd_oe, busy, cmd_data;

    // Address/data latched while the write strobe is low
    always_ff @(posedge FCLK_IN or negedge RST_N) begin
        if (!RST_N) wr_q <= '0;
        else if (!WR_B) wr_q <= '{addr: ADD, data: BUS_DATA};
    end

    // 2-FF synchronisers plus one history stage for edge detection
    always_ff @(posedge FCLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            wr_sync   <= 3'b111;  // WR_B idles high: no phantom write after reset
            trig_sync <= 3'b000;
        end else begin
            wr_sync   <= {wr_sync[1:0], WR_B};
            trig_sync <= {trig_sync[1:0], RJ45_TRIGGER};
        end
    end

    assign wr_rise   = wr_sync[1] & ~wr_sync[2];
    assign trig_rise = trig_sync[1] & ~trig_sync[2] & en_ext_q;
    assign in_mem_wr = (wr_q.addr >= ADDR_DATA) && ({1'b0, wr_q.addr} < ADDR_END);
    assign mem_we    = wr_rise & in_mem_wr;
    assign soft_rst  = wr_rise && (wr_q.addr == ADDR_CMD_BASE);

    // Register file writes and the merged start pulse
    always_ff @(posedge FCLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            en_ext_q <= 1'b0;
            size_q   <= '0;
            rep_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            start_q <= (wr_rise && wr_q.addr == ADDR_START) || trig_rise;
            if (wr_rise) begin
                if (wr_q.addr == ADDR_EN_EXT)         en_ext_q     <= wr_q.data[0];
                if (wr_q.addr == ADDR_SIZE)           size_q[7:0]  <= wr_q.data;
                if (wr_q.addr == ADDR_SIZE + 16'd1)   size_q[15:8] <= wr_q.data;
                if (wr_q.addr == ADDR_REPEAT)         rep_q[7:0]   <= wr_q.data;
                if (wr_q.addr == ADDR_REPEAT + 16'd1) rep_q[15:8]  <= wr_q.data;
            end
        end
    end

    cmd_seq_core #(.MEM_BYTES(MEM_BYTES)) u_core (
        .FCLK_IN    (FCLK_IN),
        .RST_N      (RST_N),
        .soft_rst   (soft_rst),
        .start      (start_q),
        .size       (size_q),
        .repeat_cnt (rep_q),
        .mem_we     (mem_we),
        .mem_waddr  (AW'(wr_q.addr - ADDR_DATA)),
        .mem_wdata  (wr_q.data),
        .mem_raddr  (AW'(ADD - ADDR_DATA)),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .cmd_data   (cmd_data)
    );

    // Read mux; unmapped addresses below the memory window read zero
    always_comb begin
        rd_data = 8'h00;
        if (ADD >= ADDR_DATA) rd_data = mem_rdata;
        else if (ADD == ADDR_CMD_BASE)       rd_data = VERSION;
        else if (ADD == ADDR_START)          rd_data = {7'd0, ~busy};
        else if (ADD == ADDR_EN_EXT)         rd_data = {7'd0, en_ext_q};
        else if (ADD == ADDR_SIZE)           rd_data = size_q[7:0];
        else if (ADD == ADDR_SIZE + 16'd1)   rd_data = size_q[15:8];
        else if (ADD == ADDR_REPEAT)         rd_data = rep_q[7:0];
        else if (ADD == ADDR_REPEAT + 16'd1) rd_data = rep_q[15:8];
    end

    assign rd_oe    = !RD_B && ({1'b0, ADD} < ADDR_END);
    assign BUS_DATA = rd_oe ? rd_data : 8'hzz;

    assign CMD_CLK  = ~FCLK_IN;
    assign CMD_DATA = cmd_data;
    assign TX       = {1'b0, busy, 1'b0};
    assign LED1     = busy;

endmodule

// File: tb/tb_multi_io_top.sv
// Directed bench for multi_io_top: bus access, pattern serialisation, triggers, resets.
`timescale 1ns/1ps
module tb_multi_io_top;
    import multi_io_pkg::*;

    logic        FCLK_IN = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] ADD = '0;
    logic        RD_B = 1'b1;
    logic        WR_B = 1'b1;
    logic        RJ45_TRIGGER = 1'b0;
    logic        CMD_CLK, CMD_DATA, LED1;
    logic [2:0]  TX;
    logic        tb_oe = 1'b0;
    logic [7:0]  tb_dout = '0;
    wire  [7:0]  bus_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] bits;
    int          nbusy, nrdy_lo, nled_bad;
    logic [7:0]  rd;

    always #10 FCLK_IN = ~FCLK_IN;

    assign bus_data = tb_oe ? tb_dout : 8'hzz;
    pullup (bus_data);

    multi_io_top #(.MEM_BYTES(2048), .VERSION(8'd1)) dut (
        .FCLK_IN      (FCLK_IN),
        .RST_N        (RST_N),
        .ADD          (ADD),
        .BUS_DATA     (bus_data),
        .RD_B         (RD_B),
        .WR_B         (WR_B),
        .RJ45_TRIGGER (RJ45_TRIGGER),
        .CMD_CLK      (CMD_CLK),
        .CMD_DATA     (CMD_DATA),
        .TX           (TX),
        .LED1         (LED1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns #1 after the edge on which the write has taken effect
    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge FCLK_IN); #1;
        ADD = a; tb_dout = d; tb_oe = 1'b1; WR_B = 1'b0;
        @(posedge FCLK_IN); #1;
        WR_B = 1'b1; tb_oe = 1'b0;
        repeat (3) @(posedge FCLK_IN);
        #1;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
        @(posedge FCLK_IN); #1;
        ADD = a; RD_B = 1'b0;
        #3 d = bus_data;
        RD_B = 1'b1;
    endtask

    // Sample n cycles of CMD_DATA (first bit ends up most significant)
    task automatic collect(input int n, output logic [31:0] b, output int nb,
                           output int nr, output int nl);
        b = '0; nb = 0; nr = 0; nl = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge FCLK_IN); #1;
            b  = {b[30:0], CMD_DATA};
            nb += int'(TX[1]);
            if (LED1 !== TX[1] || TX[0] !== 1'b0 || TX[2] !== 1'b0) nl++;
            ADD = ADDR_START; RD_B = 1'b0;
            #2 if (bus_data[0] === 1'b0) nr++;
            RD_B = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n, output int nb);
        nb = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge FCLK_IN); #1;
            nb += int'(TX[1] | CMD_DATA);
        end
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge FCLK_IN);
        #1;
        chk("rst_cmd_data", {31'd0, CMD_DATA}, 32'd0);
        chk("rst_tx", {29'd0, TX}, 32'd0);
        chk("rst_led", {31'd0, LED1}, 32'd0);
        chk("cmd_clk_inv", {31'd0, CMD_CLK}, {31'd0, ~FCLK_IN});
        RST_N = 1'b1;
        bus_rd(ADDR_START, rd);    chk("rst_ready", {24'd0, rd}, 32'h01);
        bus_rd(ADDR_SIZE, rd);     chk("rst_size", {24'd0, rd}, 32'h00);
        bus_rd(ADDR_REPEAT, rd);   chk("rst_repeat", {24'd0, rd}, 32'h00);
        bus_rd(ADDR_EN_EXT, rd);   chk("rst_en_ext", {24'd0, rd}, 32'h00);

        // ---- SIZE=0: START ignored ----
        bus_wr(ADDR_START, 8'h01);
        idle_cycles(6, nbusy);
        chk("size0_no_start", nbusy, 0);

        // ---- 11-bit pattern, sent once ----
        bus_wr(16'h0010, 8'h81);
        bus_wr(16'h0011, 8'h7E);
        bus_wr(16'h0012, 8'hA1);
        bus_wr(ADDR_SIZE, 8'd11);
        bus_wr(ADDR_START, 8'h01);
        collect(11, bits, nbusy, nrdy_lo, nled_bad);
        chk("p11_bits", bits, 32'b100_0000_1011);
        chk("p11_busy", nbusy, 11);
        chk("p11_ready_lo", nrdy_lo, 11);
        chk("p11_led_tx", nled_bad, 0);
        collect(1, bits, nbusy, nrdy_lo, nled_bad);
        chk("p11_after_busy", nbusy, 0);
        chk("p11_after_ready", nrdy_lo, 0);
        chk("p11_after_data", bits, 0);

        // ---- LV1 ----
        bus_wr(16'h0010, 8'hE8);
        bus_wr(ADDR_SIZE, 8'd5);
        bus_wr(ADDR_START, 8'h01);
        collect(5, bits, nbusy, nrdy_lo, nled_bad);
        chk("lv1_bits", bits, {27'd0, CMD_LV1});
        chk("lv1_busy", nbusy, 5);
        idle_cycles(3, nbusy);
        chk("lv1_idle", nbusy, 0);

        // ---- ECR repeated three times ----
        bus_wr(16'h0010, 8'hB1);
        bus_wr(16'h0011, 8'h00);
        bus_wr(ADDR_SIZE, 8'd9);
        bus_wr(ADDR_REPEAT, 8'd3);
        bus_wr(ADDR_START, 8'h01);
        collect(27, bits, nbusy, nrdy_lo, nled_bad);
        chk("ecr_bits", bits, {5'd0, {3{CMD_FIELD1, CMD_ECR}}});
        chk("ecr_busy", nbusy, 27);
        idle_cycles(4, nbusy);
        chk("ecr_idle", nbusy, 0);

        // ---- external trigger, LV1 once ----
        bus_wr(16'h0010, 8'hE8);
        bus_wr(ADDR_SIZE, 8'd5);
        bus_wr(ADDR_REPEAT, 8'd0);
        bus_wr(ADDR_EN_EXT, 8'h01);
        @(posedge FCLK_IN); #1;
        RJ45_TRIGGER = 1'b1;
        fork begin #150 RJ45_TRIGGER = 1'b0; end join_none
        repeat (3) @(posedge FCLK_IN);
        #1 chk("ext_not_yet", {31'd0, TX[1]}, 32'd0);
        collect(5, bits, nbusy, nrdy_lo, nled_bad);
        chk("ext_lv1_bits", bits, {27'd0, CMD_LV1});
        chk("ext_lv1_busy", nbusy, 5);
        idle_cycles(6, nbusy);
        chk("ext_lv1_idle", nbusy, 0);

        // ---- second trigger pulse while busy is ignored ----
        bus_wr(ADDR_REPEAT, 8'd3);
        @(posedge FCLK_IN); #1;
        RJ45_TRIGGER = 1'b1;
        fork begin
            #150 RJ45_TRIGGER = 1'b0;
            #60  RJ45_TRIGGER = 1'b1;
            #150 RJ45_TRIGGER = 1'b0;
        end join_none
        repeat (3) @(posedge FCLK_IN);
        collect(15, bits, nbusy, nrdy_lo, nled_bad);
        chk("ext_rep_bits", bits, {17'd0, {3{CMD_LV1}}});
        chk("ext_rep_busy", nbusy, 15);
        idle_cycles(12, nbusy);
        chk("ext_retrig_ignored", nbusy, 0);

        // ---- EN_EXT_START=0: trigger has no effect ----
        bus_wr(ADDR_EN_EXT, 8'h00);
        @(posedge FCLK_IN); #1;
        RJ45_TRIGGER = 1'b1;
        fork begin #150 RJ45_TRIGGER = 1'b0; end join_none
        idle_cycles(12, nbusy);
        chk("ext_disabled", nbusy, 0);

        // ---- soft reset mid-pattern, then replay from bit 0 ----
        bus_wr(16'h0010, 8'hB1);
        bus_wr(ADDR_SIZE, 8'd9);
        bus_wr(ADDR_START, 8'h01);
        collect(4, bits, nbusy, nrdy_lo, nled_bad);
        chk("srst_pre_bits", bits, 32'b1011);
        bus_wr(ADDR_CMD_BASE, 8'hFF);
        chk("srst_busy", {31'd0, TX[1]}, 32'd0);
        chk("srst_data", {31'd0, CMD_DATA}, 32'd0);
        bus_rd(ADDR_START, rd);   chk("srst_ready", {24'd0, rd}, 32'h01);
        bus_rd(ADDR_SIZE, rd);    chk("srst_size_kept", {24'd0, rd}, 32'd9);
        bus_wr(ADDR_START, 8'h01);
        collect(9, bits, nbusy, nrdy_lo, nled_bad);
        chk("srst_replay_bits", bits, {23'd0, CMD_FIELD1, CMD_ECR});
        collect(18, bits, nbusy, nrdy_lo, nled_bad);
        chk("srst_replay_rest", bits, {14'd0, {2{CMD_FIELD1, CMD_ECR}}});
        idle_cycles(2, nbusy);
        chk("srst_replay_idle", nbusy, 0);

        // ---- readback ----
        bus_wr(ADDR_SIZE, 8'h34);
        bus_wr(ADDR_SIZE + 16'd1, 8'h12);
        bus_wr(ADDR_REPEAT, 8'h02);
        bus_wr(ADDR_REPEAT + 16'd1, 8'h01);
        bus_wr(16'h080F, 8'h5A);
        bus_rd(ADDR_SIZE, rd);            chk("rd_size_lo", {24'd0, rd}, 32'h34);
        bus_rd(ADDR_SIZE + 16'd1, rd);    chk("rd_size_hi", {24'd0, rd}, 32'h12);
        bus_rd(ADDR_REPEAT, rd);          chk("rd_rep_lo", {24'd0, rd}, 32'h02);
        bus_rd(ADDR_REPEAT + 16'd1, rd);  chk("rd_rep_hi", {24'd0, rd}, 32'h01);
        bus_rd(16'h0010, rd);             chk("rd_mem0", {24'd0, rd}, 32'hB1);
        bus_rd(16'h0012, rd);             chk("rd_mem2", {24'd0, rd}, 32'hA1);
        bus_rd(16'h080F, rd);             chk("rd_mem_last", {24'd0, rd}, 32'h5A);
        bus_rd(ADDR_CMD_BASE, rd);        chk("rd_version", {24'd0, rd}, 32'h01);
        bus_rd(16'h0008, rd);             chk("rd_unmapped", {24'd0, rd}, 32'h00);
        bus_rd(16'h0810, rd);             chk("rd_beyond_hiz", {24'd0, rd}, 32'hFF);
        @(posedge FCLK_IN); #1;
        ADD = ADDR_CMD_BASE; RD_B = 1'b1;
        #2 chk("rd_b_high_hiz", {24'd0, bus_data}, 32'hFF);

        // ---- asynchronous reset mid-send ----
        bus_wr(ADDR_SIZE, 8'd9);
        bus_wr(ADDR_SIZE + 16'd1, 8'd0);
        bus_wr(ADDR_START, 8'h01);
        collect(3, bits, nbusy, nrdy_lo, nled_bad);
        chk("arst_pre_busy", nbusy, 3);
        #3 RST_N = 1'b0;
        #1;
        chk("arst_data", {31'd0, CMD_DATA}, 32'd0);
        chk("arst_tx", {29'd0, TX}, 32'd0);
        chk("arst_led", {31'd0, LED1}, 32'd0);
        bus_rd(ADDR_SIZE, rd);   chk("arst_size", {24'd0, rd}, 32'd0);
        bus_rd(ADDR_START, rd);  chk("arst_ready", {24'd0, rd}, 32'h01);
        RST_N = 1'b1;
        repeat (2) @(posedge FCLK_IN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
